ibuffer_mw: RTL and testbench
=============================

Name: ibuffer_mw

Overview:
Parametrised multi-wide instruction buffer between the fetch aligner and decode. It accepts up to FETCH_W instructions per cycle. Valid lanes are compacted in lane order and each lane gets its own PC. Decode can consume up to DEQ_W instructions per cycle from a circular queue. The block provides flush, decode stall, a low-watermark fetch request and occupancy status.

Parameters:
FETCH_W, 2, enqueue lanes per cycle (1..4)
DEQ_W, 2, dequeue lanes per cycle (1..4)
DEPTH, 16, entries; power of two, >= 2*max(FETCH_W,DEQ_W)
INST_W, 32, instruction width
PC_W, 48, stored PC width
LOW_WM, 4, fetch_req threshold, 0 < LOW_WM < DEPTH

Ports:
clock  in  1  clock
reset_n  in  1  async active-low reset
enq_valid  in  FETCH_W  per-lane valid, any mask allowed
enq_inst  in  FETCH_W*INST_W  lane i at [i*INST_W +: INST_W]
enq_pc  in  PC_W  PC of lane 0
enq_ready  out  1  free entries >= FETCH_W
deq_valid  out  DEQ_W  thermometer mask, lane 0 oldest
deq_inst  out  DEQ_W*INST_W  head-relative entries
deq_pc  out  DEQ_W*PC_W  matching PCs
deq_take  in  $clog2(DEQ_W+1)  entries consumed this cycle
stall  in  1  decode/memory stall
flush  in  1  discard all contents
fetch_req  out  1  registered refill request
count  out  $clog2(DEPTH+1)  occupancy
empty  out  1  count==0
full  out  1  count==DEPTH

Behaviour:
- Reset (async, reset_n low): rd_ptr=0, wr_ptr=0, count=0, fetch_req=0. After reset, empty=1, full=0, enq_ready=1, deq_valid=0. Entry storage is not reset.
- Lane PC: lane i PC = enq_pc + 4*i, computed modulo 2^PC_W. The PC depends on the lane index, not the compacted slot.
- Enqueue fire = enq_ready & |enq_valid & ~flush.
  - On fire, valid lanes are written in ascending lane order to wr_ptr, wr_ptr+1, ...
  - Holes in the mask are skipped, e.g. mask 10 writes lane 1 only, with PC enq_pc+4.
  - wr_ptr advances by popcount(enq_valid).
- enq_ready is computed from the current count only (DEPTH-count >= FETCH_W). Same-cycle dequeue does not raise it.
- Dequeue:
  - deq_valid[j] = (count > j) & ~stall & ~flush.
  - deq_inst/deq_pc lane j = entry (rd_ptr+j) mod DEPTH. The data is combinational from storage, so read latency is 0.
  - Consumed amount = min(deq_take, popcount(deq_valid)). A deq_take above that is clamped, never underflows, and is a bench assertion error.
  - rd_ptr advances by the consumed amount.
- Simultaneous enqueue and dequeue: count_next = count + enq_n - deq_n. Write-after-read to the same slot cannot occur because enq_ready is conservative.
- Write-to-read latency: an entry written at edge N is visible on deq lanes in cycle N+1.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Lanes crossing the wrap boundary (e.g. wr_ptr=DEPTH-1, 2 lanes) write slots DEPTH-1 and 0.
- flush:
  - At the next edge, rd_ptr=wr_ptr=0 and count=0.
  - Enqueue in the flush cycle is dropped.
  - deq_valid is forced 0 in the flush cycle.
  - fetch_req is forced to 1 on that edge, because the buffer is empty.
- fetch_req is registered: fetch_req <= (count_next <= LOW_WM) | flush. It is held while the condition holds, not pulsed.
- stall does not block enqueue, only dequeue.
- Async reset mid-operation discards all state immediately. Outputs take reset values combinationally.

Decomposition:
- Shared package ibuf_pkg:
  - localparams for the default INST_W/PC_W and the PC step (4)
  - typedef ibuf_entry_t {inst, pc}
  - function popcount_lanes
- One sub-module, ibuf_compact: combinational lane compaction. It maps FETCH_W valid lanes to dense slot offsets 0..n-1 with per-lane PC, and outputs enq_n.
- Pointer, count and storage logic stays in ibuffer_mw.

Test Plan:
- Reset, then enq mask 11, inst {B,A}, pc 0x1000 -> next cycle count=2, deq lane0 = A@0x1000, lane1 = B@0x1004, fetch_req=1 (2 <= 4).
- Hole compaction: mask 10, inst {D,C}, pc 0x2000 -> only D stored, at 0x2004, count +1, deq lane0 = D.
- Fill to 15 with no dequeue -> enq_ready=0, full=0. Enq attempts with ready=0 leave count 15, and nothing is written.
- Wrap: with rd_ptr=wr_ptr=15 and count=0, enq mask 11 -> slots 15 and 0 written, deq returns both in order. deq_take=2 -> rd_ptr=1, empty=1.
- Simultaneous: count=6, stall=0, enq 2 lanes and deq_take=2 -> count stays 6. Same cycle with stall=1 -> deq_valid=0, count=8. deq_take=3 on a DEQ_W=2 build is clamped to 2 and flagged.
- flush with count=10 while enqueuing 2 lanes -> next cycle count=0, empty=1, fetch_req=1, enqueued data absent. Reset_n pulse mid-fill gives count=0 immediately.

Source files
------------

// File: rtl/ibuffer_mw_pkg.sv
// Shared types and helpers for the multi-wide instruction buffer.
// Holds default widths, the per-lane PC step, the entry layout and a lane popcount.
package ibuf_pkg;

    localparam int INST_W_DEF = 32;
    localparam int PC_W_DEF   = 48;
    localparam int PC_STEP    = 4;

    typedef struct packed {
        logic [INST_W_DEF-1:0] inst;
        logic [PC_W_DEF-1:0]   pc;
    } ibuf_entry_t;

    // Lane masks are at most 4 wide; narrower masks are zero-extended by callers.
    function automatic logic [2:0] popcount_lanes(input logic [3:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/ibuffer_mw_if.sv
// Fetch/decode side bundle of the instruction buffer.
// master = fetch aligner + decode, slave = the buffer itself.
interface ibuffer_mw_if #(
    parameter int FETCH_W = 2,
    parameter int DEQ_W   = 2,
    parameter int DEPTH   = 16,
    parameter int INST_W  = 32,
    parameter int PC_W    = 48
);

    logic [FETCH_W-1:0]          enq_valid;
    logic [FETCH_W*INST_W-1:0]   enq_inst;
    logic [PC_W-1:0]             enq_pc;
    logic                        enq_ready;
    logic [DEQ_W-1:0]            deq_valid;
    logic [DEQ_W*INST_W-1:0]     deq_inst;
    logic [DEQ_W*PC_W-1:0]       deq_pc;
    logic [$clog2(DEQ_W+1)-1:0]  deq_take;
    logic                        stall;
    logic                        flush;
    logic                        fetch_req;
    logic [$clog2(DEPTH+1)-1:0]  count;
    logic                        empty;
    logic                        full;

    modport master (
        output enq_valid, enq_inst, enq_pc,
        output deq_take, stall, flush,
        input  enq_ready, deq_valid, deq_inst, deq_pc,
        input  fetch_req, count, empty, full
    );

    modport slave (
        input  enq_valid, enq_inst, enq_pc,
        input  deq_take, stall, flush,
        output enq_ready, deq_valid, deq_inst, deq_pc,
        output fetch_req, count, empty, full
    );

endinterface

// File: rtl/ibuffer_mw_compact.sv
// Combinational lane compaction: valid lanes packed densely in lane order.
// Ports: i_valid/i_inst/i_pc lane inputs; o_slot_inst/o_slot_pc dense slots; o_n count.
module ibuf_compact
    import ibuf_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int INST_W  = 32,
    parameter int PC_W    = 48
) (
    input  logic [FETCH_W-1:0]          i_valid,
    input  logic [FETCH_W*INST_W-1:0]   i_inst,
    input  logic [PC_W-1:0]             i_pc,
    output logic [FETCH_W*INST_W-1:0]   o_slot_inst,
    output logic [FETCH_W*PC_W-1:0]     o_slot_pc,
    output logic [$clog2(FETCH_W+1)-1:0] o_n
);

    localparam int NW = $clog2(FETCH_W + 1);

    // PC follows the source lane index, not the slot it lands in.
    always_comb begin : p_compact
        int k;
        k = 0;
        o_slot_inst = '0;
        o_slot_pc   = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            if (i_valid[i]) begin
                o_slot_inst[k*INST_W +: INST_W] = i_inst[i*INST_W +: INST_W];
                o_slot_pc[k*PC_W +: PC_W] = i_pc + PC_W'(PC_STEP * i);
                k = k + 1;
            end
        end
    end

    assign o_n = NW'(popcount_lanes(4'(i_valid)));

endmodule

// File: rtl/ibuffer_mw.sv
// Multi-wide circular instruction buffer between fetch aligner and decode.
// Ports: clock, reset_n (async low), bus (enqueue, dequeue, flush/stall, status).
module ibuffer_mw
    import ibuf_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int DEQ_W   = 2,
    parameter int DEPTH   = 16,
    parameter int INST_W  = INST_W_DEF,
    parameter int PC_W    = PC_W_DEF,
    parameter int LOW_WM  = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    ibuffer_mw_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(FETCH_W + 1);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } entry_t;

    entry_t                    r_mem [DEPTH];
    logic [PW-1:0]             r_rd_ptr;
    logic [PW-1:0]             r_wr_ptr;
    logic [CW-1:0]             r_count;
    logic                      r_fetch_req;

    logic [FETCH_W*INST_W-1:0] w_slot_inst;
    logic [FETCH_W*PC_W-1:0]   w_slot_pc;
    logic [NW-1:0]             w_enq_n;
    logic                      w_enq_ready;
    logic                      w_enq_fire;
    logic [DEQ_W-1:0]          w_deq_valid;
    logic [DEQ_W*INST_W-1:0]   w_deq_inst;
    logic [DEQ_W*PC_W-1:0]     w_deq_pc;
    logic [2:0]                w_deq_avail;
    logic [2:0]                w_deq_req;
    logic [2:0]                w_deq_n;
    logic [CW-1:0]             w_count_next;
    logic [PW-1:0]             w_rd_next;
    logic [PW-1:0]             w_wr_next;

    ibuf_compact #(
        .FETCH_W (FETCH_W),
        .INST_W  (INST_W),
        .PC_W    (PC_W)
    ) u_compact (
        .i_valid     (bus.enq_valid),
        .i_inst      (bus.enq_inst),
        .i_pc        (bus.enq_pc),
        .o_slot_inst (w_slot_inst),
        .o_slot_pc   (w_slot_pc),
        .o_n         (w_enq_n)
    );

    // Ready looks only at current occupancy, so a same-cycle
    // dequeue never lets a write land on a slot still being read.
    assign w_enq_ready = r_count <= CW'(DEPTH - FETCH_W);
    assign w_enq_fire  = w_enq_ready & (|bus.enq_valid) & ~bus.flush;

    always_comb begin
        w_deq_valid = '0;
        w_deq_inst  = '0;
        w_deq_pc    = '0;
        for (int j = 0; j < DEQ_W; j++) begin
            w_deq_valid[j] = (r_count > CW'(j)) & ~bus.stall & ~bus.flush;
            w_deq_inst[j*INST_W +: INST_W] = r_mem[r_rd_ptr + PW'(j)].inst;
            w_deq_pc[j*PC_W +: PC_W]       = r_mem[r_rd_ptr + PW'(j)].pc;
        end
    end

    // Over-asking decode is clamped to what is actually presented.
    assign w_deq_avail = popcount_lanes(4'(w_deq_valid));
    assign w_deq_req   = 3'(bus.deq_take);
    assign w_deq_n     = (w_deq_req > w_deq_avail) ? w_deq_avail : w_deq_req;

    always_comb begin
        w_count_next = r_count;
        w_rd_next    = r_rd_ptr;
        w_wr_next    = r_wr_ptr;
        if (bus.flush) begin
            w_count_next = '0;
            w_rd_next    = '0;
            w_wr_next    = '0;
        end else begin
            w_count_next = r_count
                         + (w_enq_fire ? CW'(w_enq_n) : '0)
                         - CW'(w_deq_n);
            w_wr_next    = r_wr_ptr + (w_enq_fire ? PW'(w_enq_n) : '0);
            w_rd_next    = r_rd_ptr + PW'(w_deq_n);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_fetch_req <= 1'b0;
        end else begin
            r_rd_ptr    <= w_rd_next;
            r_wr_ptr    <= w_wr_next;
            r_count     <= w_count_next;
            r_fetch_req <= (w_count_next <= CW'(LOW_WM)) | bus.flush;
        end
    end

    // Storage carries no reset; pointer wrap handles the boundary.
    always_ff @(posedge clock) begin
        if (w_enq_fire) begin
            for (int k = 0; k < FETCH_W; k++) begin
                if (NW'(k) < w_enq_n) begin
                    r_mem[r_wr_ptr + PW'(k)] <= '{
                        inst: w_slot_inst[k*INST_W +: INST_W],
                        pc:   w_slot_pc[k*PC_W +: PC_W]
                    };
                end
            end
        end
    end

    assign bus.enq_ready = w_enq_ready;
    assign bus.deq_valid = w_deq_valid;
    assign bus.deq_inst  = w_deq_inst;
    assign bus.deq_pc    = w_deq_pc;
    assign bus.fetch_req = r_fetch_req;
    assign bus.count     = r_count;
    assign bus.empty     = (r_count == '0);
    assign bus.full      = (r_count == CW'(DEPTH));

endmodule

// File: tb/tb_ibuffer_mw.sv
// Scoreboard bench for ibuffer_mw (FETCH_W=2, DEQ_W=2, DEPTH=16).
// Stimulus pushes expected entries; a negedge monitor pops and compares.
module tb_ibuffer_mw;

    localparam int FETCH_W = 2;
    localparam int DEQ_W   = 2;
    localparam int DEPTH   = 16;
    localparam int INST_W  = 32;
    localparam int PC_W    = 48;
    localparam int LOW_WM  = 4;

    typedef struct {
        logic [31:0] inst;
        logic [47:0] pc;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   overtake = 0;

    always #5 clock = ~clock;

    ibuffer_mw_if #(
        .FETCH_W (FETCH_W),
        .DEQ_W   (DEQ_W),
        .DEPTH   (DEPTH),
        .INST_W  (INST_W),
        .PC_W    (PC_W)
    ) bus ();

    ibuffer_mw #(
        .FETCH_W (FETCH_W),
        .DEQ_W   (DEQ_W),
        .DEPTH   (DEPTH),
        .INST_W  (INST_W),
        .PC_W    (PC_W),
        .LOW_WM  (LOW_WM)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.enq_valid = '0;
        bus.enq_inst  = '0;
        bus.enq_pc    = '0;
        bus.deq_take  = '0;
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic exp_push(input logic [31:0] inst, input logic [47:0] pc);
        exp_t e;
        e.inst = inst;
        e.pc   = pc;
        sb.push_back(e);
    endtask

    task automatic drive_enq(input logic [1:0] m, input logic [31:0] i1,
                             input logic [31:0] i0, input logic [47:0] pc);
        bus.enq_valid = m;
        bus.enq_inst  = {i1, i0};
        bus.enq_pc    = pc;
    endtask

    task automatic fill(input int n, input logic [31:0] ib,
                        input logic [47:0] pcb);
        int rem;
        logic [31:0] i;
        logic [47:0] p;
        rem = n;
        i = ib;
        p = pcb;
        while (rem > 0) begin
            check("fill_ready", 64'(bus.enq_ready), 64'd1);
            if (rem >= 2) begin
                drive_enq(2'b11, i + 1, i, p);
                exp_push(i, p);
                exp_push(i + 1, p + 48'd4);
                rem -= 2;
            end else begin
                drive_enq(2'b01, 32'hDEAD_0000, i, p);
                exp_push(i, p);
                rem -= 1;
            end
            i += 2;
            p += 48'd8;
            tick();
        end
        idle();
    endtask

    task automatic drain(input int n);
        int rem;
        rem = n;
        while (rem > 0) begin
            bus.deq_take = (rem >= 2) ? 2'd2 : 2'd1;
            rem -= int'(bus.deq_take);
            tick();
        end
        bus.deq_take = '0;
    endtask

    always @(negedge clock) begin
        int nv;
        int take;
        int n;
        if (reset_n) begin
            nv = 0;
            for (int j = 0; j < DEQ_W; j++) begin
                if (bus.deq_valid[j]) begin
                    nv++;
                    if (j < sb.size()) begin
                        check($sformatf("mon_inst_l%0d", j),
                              64'(bus.deq_inst[j*INST_W +: INST_W]),
                              64'(sb[j].inst));
                        check($sformatf("mon_pc_l%0d", j),
                              64'(bus.deq_pc[j*PC_W +: PC_W]),
                              64'(sb[j].pc));
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL mon_extra_l%0d: lane valid, expected none", j);
                    end
                end
            end
            take = int'(bus.deq_take);
            if (take > nv) begin
                overtake++;
                $display("note: deq_take %0d above %0d valid lanes, clamped",
                         take, nv);
            end
            n = (take > nv) ? nv : take;
            repeat (n) begin
                if (sb.size() > 0) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        idle();
        repeat (3) @(posedge clock);
        #1;
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_empty", 64'(bus.empty), 64'd1);
        check("rst_full", 64'(bus.full), 64'd0);
        check("rst_ready", 64'(bus.enq_ready), 64'd1);
        check("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
        check("rst_fetch_req", 64'(bus.fetch_req), 64'd0);
        reset_n = 1'b1;
        tick();

        // two lanes, PCs per lane
        drive_enq(2'b11, 32'hB0B0_000B, 32'hA0A0_000A, 48'h1000);
        exp_push(32'hA0A0_000A, 48'h1000);
        exp_push(32'hB0B0_000B, 48'h1004);
        tick();
        idle();
        check("t1_count", 64'(bus.count), 64'd2);
        check("t1_deq_valid", 64'(bus.deq_valid), 64'h3);
        check("t1_fetch_req", 64'(bus.fetch_req), 64'd1);
        check("t1_l0_inst", 64'(bus.deq_inst[31:0]), 64'hA0A0_000A);
        check("t1_l1_pc", 64'(bus.deq_pc[95:48]), 64'h1004);
        drain(2);
        check("t1_empty", 64'(bus.empty), 64'd1);

        // hole in mask: only lane 1 stored, PC +4
        drive_enq(2'b10, 32'hD0D0_000D, 32'hC0C0_000C, 48'h2000);
        exp_push(32'hD0D0_000D, 48'h2004);
        tick();
        idle();
        check("t2_count", 64'(bus.count), 64'd1);
        check("t2_deq_valid", 64'(bus.deq_valid), 64'h1);
        check("t2_l0_inst", 64'(bus.deq_inst[31:0]), 64'hD0D0_000D);
        check("t2_l0_pc", 64'(bus.deq_pc[47:0]), 64'h2004);
        drain(1);

        // fill to 15, then blocked attempts
        fill(15, 32'h0000_0100, 48'h3000);
        check("t3_count", 64'(bus.count), 64'd15);
        check("t3_ready", 64'(bus.enq_ready), 64'd0);
        check("t3_full", 64'(bus.full), 64'd0);
        check("t3_fetch_req", 64'(bus.fetch_req), 64'd0);
        drive_enq(2'b11, 32'h9999_0001, 32'h9999_0000, 48'h9000);
        tick();
        tick();
        idle();
        check("t3_blocked_count", 64'(bus.count), 64'd15);
        drain(15);
        check("t3_drained", 64'(bus.empty), 64'd1);

        // move pointers to 15
        fill(13, 32'h0000_0200, 48'h7000);
        drain(13);
        check("t4_pre_empty", 64'(bus.empty), 64'd1);

        // wrap: slots 15 and 0
        drive_enq(2'b11, 32'hF1F1_0001, 32'hF0F0_0000, 48'h4000);
        exp_push(32'hF0F0_0000, 48'h4000);
        exp_push(32'hF1F1_0001, 48'h4004);
        tick();
        idle();
        check("t4_count", 64'(bus.count), 64'd2);
        check("t4_l0_inst", 64'(bus.deq_inst[31:0]), 64'hF0F0_0000);
        check("t4_l1_inst", 64'(bus.deq_inst[63:32]), 64'hF1F1_0001);
        drain(2);
        check("t4_empty", 64'(bus.empty), 64'd1);

        // simultaneous enqueue and dequeue
        fill(6, 32'h0000_0300, 48'h5000);
        drive_enq(2'b11, 32'h0000_5101, 32'h0000_5100, 48'h5800);
        exp_push(32'h0000_5100, 48'h5800);
        exp_push(32'h0000_5101, 48'h5804);
        bus.deq_take = 2'd2;
        tick();
        idle();
        check("t5_count_same", 64'(bus.count), 64'd6);
        drive_enq(2'b11, 32'h0000_5201, 32'h0000_5200, 48'h5900);
        exp_push(32'h0000_5200, 48'h5900);
        exp_push(32'h0000_5201, 48'h5904);
        bus.deq_take = 2'd2;
        bus.stall = 1'b1;
        #1;
        check("t5_stall_valid", 64'(bus.deq_valid), 64'd0);
        tick();
        idle();
        check("t5_stall_count", 64'(bus.count), 64'd8);
        bus.deq_take = 2'd3;
        #1;
        check("t5_take3_valid", 64'(bus.deq_valid), 64'h3);
        tick();
        idle();
        check("t5_take3_count", 64'(bus.count), 64'd6);

        // flush while enqueueing
        fill(4, 32'h0000_0400, 48'h5A00);
        check("t6_pre_count", 64'(bus.count), 64'd10);
        drive_enq(2'b11, 32'h0BAD_0001, 32'h0BAD_0000, 48'h6F00);
        bus.flush = 1'b1;
        #1;
        check("t6_flush_valid", 64'(bus.deq_valid), 64'd0);
        sb.delete();
        tick();
        idle();
        check("t6_count", 64'(bus.count), 64'd0);
        check("t6_empty", 64'(bus.empty), 64'd1);
        check("t6_fetch_req", 64'(bus.fetch_req), 64'd1);
        check("t6_deq_valid", 64'(bus.deq_valid), 64'd0);
        drive_enq(2'b01, 32'h0, 32'hEEEE_0001, 48'h6000);
        exp_push(32'hEEEE_0001, 48'h6000);
        tick();
        idle();
        check("t6_new_count", 64'(bus.count), 64'd1);
        check("t6_new_inst", 64'(bus.deq_inst[31:0]), 64'hEEEE_0001);
        drain(1);

        // async reset mid-fill
        fill(6, 32'h0000_0500, 48'h8000);
        reset_n = 1'b0;
        #1;
        check("t7_rst_count", 64'(bus.count), 64'd0);
        check("t7_rst_empty", 64'(bus.empty), 64'd1);
        check("t7_rst_fetch_req", 64'(bus.fetch_req), 64'd0);
        check("t7_rst_valid", 64'(bus.deq_valid), 64'd0);
        sb.delete();
        tick();
        reset_n = 1'b1;
        tick();
        check("t7_post_count", 64'(bus.count), 64'd0);

        check("overtake_flags", 64'(overtake), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
